// File: rtl/window_mean.sv
// window_mean
//   Sliding-window accumulator with a bit-serial restoring divider. Holds the
//   last DEPTH signed samples, keeps their running sum, and produces the
//   mean (sum / samples held, truncated toward zero) SUM_W cycles after each
//   accepted sample.
//
// Parameters
//   WIDTH  sample width, signed two's complement
//   FRAC   fractional bits (display-only, no effect on arithmetic)
//   DEPTH  window length, 2..16
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous active-high reset, highest priority
//   clear      in   synchronous datapath clear, same effect as reset
//   in_valid   in   sample strobe
//   in_data    in   signed sample [WIDTH]
//   in_ready   out  high only while idle (and not in reset)
//   sum        out  signed sum of held samples [SUM_W]
//   mean       out  signed sum/count, truncated toward zero [WIDTH]
//   out_valid  out  one-cycle pulse when mean updates
//   count      out  samples held, saturates at DEPTH [CNT_W]
//   overrun    out  sticky, set when a sample arrives while busy
module window_mean #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6,
  parameter int DEPTH = 3,
  localparam int SUM_W = WIDTH + $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic [WIDTH-1:0] mean,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ITER_W = $clog2(SUM_W);

  if (DEPTH < 2 || DEPTH > 16 || FRAC < 0 || FRAC >= WIDTH) begin : g_param_check
    $error("window_mean: illegal parameter combination");
  end

  typedef enum logic {
    ST_IDLE,
    ST_DIV
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [WIDTH-1:0]    r_buf [DEPTH];
  logic [PTR_W-1:0]    r_ptr;
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_count;
  logic [WIDTH-1:0]    r_mean;
  logic                r_out_valid;
  logic                r_overrun;

  // Divider: r_dvd shifts the dividend magnitude out at the top while
  // quotient bits shift in at the bottom.
  logic [SUM_W-1:0]    r_dvd;
  logic [CNT_W-1:0]    r_rem;
  logic [CNT_W-1:0]    r_div;
  logic                r_neg;
  logic [ITER_W-1:0]   r_iter;

  logic                w_accept;
  logic                w_full;
  logic [SUM_W-1:0]    w_samp_ext;
  logic [SUM_W-1:0]    w_old_ext;
  logic [SUM_W-1:0]    w_sum_nx;
  logic [SUM_W-1:0]    w_mag_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [CNT_W:0]      w_rem_sh;
  logic [CNT_W:0]      w_rem_diff;
  logic                w_ge;
  logic [CNT_W-1:0]    w_rem_nx;
  logic [SUM_W-1:0]    w_dvd_nx;
  logic                w_last;
  logic [WIDTH-1:0]    w_q;
  logic [WIDTH-1:0]    w_mean_nx;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = ST_DIV;
      ST_DIV:  if (w_last)   w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == ST_IDLE) && !reset;
  end

  // ------------------------------------------------------- window update
  assign w_accept   = in_valid && in_ready;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_samp_ext = {{(SUM_W-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign w_old_ext  = {{(SUM_W-WIDTH){r_buf[r_ptr][WIDTH-1]}}, r_buf[r_ptr]};
  // Once full, the pointer addresses the oldest entry, which is the one
  // being overwritten and therefore leaves the sum.
  assign w_sum_nx   = r_sum + w_samp_ext - (w_full ? w_old_ext : '0);
  assign w_cnt_nx   = w_full ? r_count : r_count + CNT_W'(1);
  assign w_mag_nx   = w_sum_nx[SUM_W-1] ? -w_sum_nx : w_sum_nx;

  // ------------------------------------------------------ divider step
  assign w_rem_sh   = {r_rem, r_dvd[SUM_W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_diff = w_rem_sh - {1'b0, r_div};
  // The partial remainder stays below the divisor, so CNT_W bits suffice.
  assign w_rem_nx   = w_ge ? w_rem_diff[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
  assign w_dvd_nx   = {r_dvd[SUM_W-2:0], w_ge};
  assign w_last     = (r_iter == ITER_W'(SUM_W - 1));
  // |mean| never exceeds the largest |sample|, so the low WIDTH bits hold it.
  assign w_q        = w_dvd_nx[WIDTH-1:0];
  assign w_mean_nx  = r_neg ? -w_q : w_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_ptr       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_mean      <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_neg       <= 1'b0;
      r_iter      <= '0;
    end else begin
      r_out_valid <= 1'b0;

      if (w_accept) begin
        r_buf[r_ptr] <= in_data;
        r_ptr        <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
        r_sum        <= w_sum_nx;
        r_count      <= w_cnt_nx;
        r_dvd        <= w_mag_nx;
        r_rem        <= '0;
        r_div        <= w_cnt_nx;
        r_neg        <= w_sum_nx[SUM_W-1];
        r_iter       <= '0;
      end

      if (r_state == ST_DIV) begin
        r_dvd  <= w_dvd_nx;
        r_rem  <= w_rem_nx;
        r_iter <= r_iter + ITER_W'(1);
        if (w_last) begin
          r_mean      <= w_mean_nx;
          r_out_valid <= 1'b1;
        end
      end

      if (in_valid && r_state != ST_IDLE) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign sum       = r_sum;
  assign count     = r_count;
  assign mean      = r_mean;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: doc/window_mean.md
# window_mean

Parametrised sliding-window accumulator and sequential signed divider that generalises the fixed three-term sum and divide-by-three path of the LFSR demo. It keeps the last DEPTH signed fixed-point samples, such as LFSR outputs stepped by KEY[3], and maintains their running sum. It then computes the mean of the samples currently held with a bit-serial restoring divider. It sits between the random-number source and the display/LED decode logic.

## Interface
- WIDTH, 8: sample width, signed two's complement (Q2.6 at default; arithmetic is plain integer, FRAC is display-only).
- FRAC, 6: fractional bits, informational; no effect on RTL arithmetic.
- DEPTH, 3: window length, legal 2..16.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; has priority over every other input.
- clear  in  1  synchronous datapath clear; same effect as reset.
- in_valid  in  1  sample strobe.
- in_data  in  WIDTH  signed sample.
- in_ready  out  1  high only in IDLE.
- sum  out  SUM_W = WIDTH+clog2(DEPTH)  signed sum of the samples held.
- mean  out  WIDTH  signed sum/count, truncated toward zero.
- out_valid  out  1  one-cycle pulse when mean updates.
- count  out  clog2(DEPTH+1)  samples held, saturates at DEPTH.
- overrun  out  1  sticky; set when a sample is dropped.

## Operation
- Storage: DEPTH-entry circular buffer with a write pointer that wraps DEPTH-1 -> 0.
- Accept condition: in_valid & in_ready.
- On accept:
  - write in_data at the pointer and advance the pointer;
  - if count<DEPTH: sum <= sum + in_data and count increments;
  - else: sum <= sum + in_data − entry being overwritten;
  - load the divider with the new sum and the new count; go to DIV.
- The sum cannot overflow SUM_W. All additions are sign-extended to SUM_W.
- FSM:
  - IDLE -> DIV on accept.
  - DIV runs SUM_W iterations on |sum| / count, one quotient bit per cycle, with an iteration counter.
  - On the final iteration: mean <= quotient negated if sum<0, out_valid <= 1, state <= IDLE.
- mean always fits WIDTH, since |mean| ≤ max|sample|. Truncate to WIDTH.
- in_valid while not in IDLE: the sample is dropped, overrun <= 1, and no state changes.
- reset or clear, including mid-DIV: state IDLE, buffer entries 0, pointer 0, sum 0, count 0, mean 0, out_valid 0, overrun 0. An aborted division never pulses out_valid.
- clear and in_valid in the same cycle: clear wins and the sample is lost. overrun is not set.

## Timing
- Reset values: in_ready 0 while reset is asserted, 1 in the first cycle after. sum 0, mean 0, out_valid 0, count 0, overrun 0.
- Accept on edge E0 updates sum and count at E0, visible in the following cycle.
- DIV occupies edges E0+1 .. E0+SUM_W. mean and out_valid are registered at E0+SUM_W. out_valid is high for exactly the cycle after that edge.
- in_ready rises in the same cycle as out_valid, so back-to-back accepts are possible.
- Throughput: one sample per SUM_W+1 cycles. At default parameters that is 11 cycles, and out_valid follows accept by 10 edges.
- mean holds between updates. sum and count change only on an accept, a clear or a reset.

## Test plan
Defaults apply: WIDTH=8, DEPTH=3, SUM_W=10.
1. Reset, then feed 30, 60, 90 (each when in_ready) -> sum 30/90/180, count 1/2/3, mean 30/45/60. out_valid arrives exactly 10 edges after each accept.
2. Continue with 120, then 0 -> window wraps: sum 270 then 210, mean 90 then 70, count stays 3.
3. Clear, then feed −128, −128, −127 -> sum −128/−256/−383, mean −128/−128/−127 (−127.67 truncated toward zero). Clear, then feed −1, −1, 1 -> mean −1, −1, 0.
4. Assert in_valid with 50 at DIV iteration 4 -> sample dropped: sum, count and the next mean unaffected; overrun=1 until clear.
5. Assert reset at DIV iteration 5 -> no out_valid; all outputs 0 next cycle; in_ready=1 after deassert. Separately, clear and in_valid (value 77) in the same IDLE cycle -> sum 0, count 0, overrun 0.
6. With WIDTH=12, DEPTH=16, feed 16 samples of 2047 then one of −2048 -> saturated sum 32752, then 28657. Means are 2047 and 1791; out_valid follows each accept by 16 edges.
